// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder in front of a NUM_REGS-word register file.
// Write (AW/W/B) and read (AR/R) paths are independent two-state machines; contents are exported on reg_out.
module axi4_lite_slave_regs #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDRESS_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDRESS_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    // Anything at or above NUM_REGS words has a nonzero bit above the index field.
    function automatic logic addr_in_range(input logic [ADDRESS_WIDTH-1:0] addr);
        return (addr >> (ADDR_LSB + IDX_WIDTH)) == '0;
    endfunction

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // ---------------- write path ----------------
    w_state_t              w_state;
    logic                  aw_captured;
    logic                  w_captured;
    logic [IDX_WIDTH-1:0]  aw_idx_q;
    logic                  aw_ok_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  wr_commit;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;

    // Ready depends only on state, never on the VALID inputs.
    assign S_AXI_AWREADY = ARESETN && (w_state == W_IDLE) && !aw_captured;
    assign S_AXI_WREADY  = ARESETN && (w_state == W_IDLE) && !w_captured;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

    // Use the held copy if already captured, otherwise the beat arriving this edge.
    assign wr_idx  = aw_captured ? aw_idx_q : S_AXI_AWADDR[ADDR_LSB +: IDX_WIDTH];
    assign wr_ok   = aw_captured ? aw_ok_q  : addr_in_range(S_AXI_AWADDR);
    assign wr_data = w_captured  ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_captured  ? w_strb_q : S_AXI_WSTRB;

    assign wr_commit = (w_state == W_IDLE) && (aw_captured || aw_hs) && (w_captured || w_hs);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state     <= W_IDLE;
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            aw_idx_q    <= '0;
            aw_ok_q     <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_captured <= 1'b1;
                        aw_idx_q    <= S_AXI_AWADDR[ADDR_LSB +: IDX_WIDTH];
                        aw_ok_q     <= addr_in_range(S_AXI_AWADDR);
                    end
                    if (w_hs) begin
                        w_captured <= 1'b1;
                        w_data_q   <= S_AXI_WDATA;
                        w_strb_q   <= S_AXI_WSTRB;
                    end
                    if (wr_commit) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        w_state  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q    <= 1'b0;
                        aw_captured <= 1'b0;
                        w_captured  <= 1'b0;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;

    // NOTE: the register file is reset because its contents are visible on reg_out straight out of reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit && wr_ok) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t              r_state;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ar_hs;

    assign S_AXI_ARREADY = ARESETN && (r_state == R_IDLE);
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

    // Reading regs here sees the pre-edge value, so a same-edge write returns the old data.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        if (addr_in_range(S_AXI_ARADDR)) begin
                            rdata_q <= regs[S_AXI_ARADDR[ADDR_LSB +: IDX_WIDTH]];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end
                        rvalid_q <= 1'b1;
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: table of single transfers plus hand-written
// sequences for channel ordering, backpressure, read/write collision and mid-transfer reset.
module tb_axi4_lite_slave_regs;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int SW = DW / 8;
    localparam int FW = NR * DW;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [AW-1:0] S_AXI_AWADDR = '0;
    logic          S_AXI_AWVALID = 1'b0;
    logic          S_AXI_AWREADY;
    logic [DW-1:0] S_AXI_WDATA = '0;
    logic [SW-1:0] S_AXI_WSTRB = '0;
    logic          S_AXI_WVALID = 1'b0;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY = 1'b0;
    logic [AW-1:0] S_AXI_ARADDR = '0;
    logic          S_AXI_ARVALID = 1'b0;
    logic          S_AXI_ARREADY;
    logic [DW-1:0] S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY = 1'b0;
    logic [FW-1:0] reg_out;

    axi4_lite_slave_regs #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .reg_out(reg_out)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } r_exp_t;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] model_regs [NR];
    logic [1:0]    b_q [$];
    r_exp_t        r_q [$];
    vec_t          vecs [14];

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model_regs[i];
        return f;
    endfunction

    task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb);
        logic [2:0] idx;
        if (addr < NR * SW) begin
            idx = addr[4:2];
            for (int b = 0; b < SW; b++)
                if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
    endtask

    // All tasks below start and end just after a rising edge.
    task automatic drive_aw(input logic [AW-1:0] addr);
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    endtask

    task automatic drive_w(input logic [DW-1:0] data, input logic [SW-1:0] strb);
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    endtask

    task automatic drive_ar(input logic [AW-1:0] addr);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    endtask

    task automatic run_handshakes(input string name);
        int   n = 0;
        logic aw_hs, w_hs, ar_hs;
        while ((S_AXI_AWVALID || S_AXI_WVALID || S_AXI_ARVALID) && n < 20) begin
            @(negedge ACLK);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
            ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs)  S_AXI_WVALID  = 1'b0;
            if (ar_hs) S_AXI_ARVALID = 1'b0;
            n++;
        end
        check({name, "_handshakes_done"}, {S_AXI_AWVALID, S_AXI_WVALID, S_AXI_ARVALID}, 3'b000);
    endtask

    task automatic collect_b(input string name);
        int         n = 0;
        logic [1:0] exp;
        @(negedge ACLK);
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        check({name, "_b_latency"}, n, 0);
        exp = (b_q.size() != 0) ? b_q.pop_front() : 2'bxx;
        check({name, "_bresp"}, S_AXI_BRESP, exp);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        check({name, "_bvalid_drop"}, S_AXI_BVALID, 1'b0);
        @(posedge ACLK); #1;
    endtask

    task automatic collect_r(input string name);
        int     n = 0;
        r_exp_t exp;
        @(negedge ACLK);
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        check({name, "_r_latency"}, n, 0);
        exp = (r_q.size() != 0) ? r_q.pop_front() : '{'x, 2'bxx};
        check({name, "_rdata"}, S_AXI_RDATA, exp.data);
        check({name, "_rresp"}, S_AXI_RRESP, exp.resp);
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        check({name, "_rvalid_drop"}, S_AXI_RVALID, 1'b0);
        @(posedge ACLK); #1;
    endtask

    task automatic do_write(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic [1:0] exp_resp);
        drive_aw(addr);
        drive_w(data, strb);
        b_q.push_back(exp_resp);
        run_handshakes(name);
        model_write(addr, data, strb);
        collect_b(name);
        check({name, "_reg_out"}, reg_out, model_flat());
    endtask

    task automatic do_read(input string name, input logic [AW-1:0] addr,
                           input logic [DW-1:0] exp_data, input logic [1:0] exp_resp) ;
        drive_ar(addr);
        r_q.push_back('{exp_data, exp_resp});
        run_handshakes(name);
        collect_r(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h0000_00AA, 4'h1, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEAA};
        vecs[4]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0006, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEAA};
        vecs[6]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_001C, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_001F, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
        vecs[10] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hC, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hCAFE_0000};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};
        model_clear();

        // Reset state
        #12;
        check("rst_awready", S_AXI_AWREADY, 1'b0);
        check("rst_wready",  S_AXI_WREADY,  1'b0);
        check("rst_arready", S_AXI_ARREADY, 1'b0);
        check("rst_valids",  {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("rst_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, '0);
        check("rst_reg_out", reg_out, '0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("post_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(posedge ACLK); #1;

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) do_write($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            else            do_read($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end

        // W three cycles ahead of AW
        drive_w(32'h1122_3344, 4'hF);
        b_q.push_back(2'b00);
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            check("wfirst_wready_low",  S_AXI_WREADY,  1'b0);
            check("wfirst_awready_high", S_AXI_AWREADY, 1'b1);
            check("wfirst_no_bvalid",   S_AXI_BVALID,  1'b0);
            @(posedge ACLK); #1;
        end
        drive_aw(32'h0000_0008);
        run_handshakes("wfirst");
        model_write(32'h0000_0008, 32'h1122_3344, 4'hF);
        collect_b("wfirst");
        check("wfirst_reg2", reg_out[95:64], 32'h1122_3344);

        // AW three cycles ahead of W
        drive_aw(32'h0000_0008);
        b_q.push_back(2'b00);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            check("awfirst_awready_low", S_AXI_AWREADY, 1'b0);
            check("awfirst_wready_high", S_AXI_WREADY,  1'b1);
            check("awfirst_no_bvalid",   S_AXI_BVALID,  1'b0);
            @(posedge ACLK); #1;
        end
        drive_w(32'h99AA_BBCC, 4'hF);
        run_handshakes("awfirst");
        model_write(32'h0000_0008, 32'h99AA_BBCC, 4'hF);
        collect_b("awfirst");
        check("awfirst_reg2", reg_out[95:64], 32'h99AA_BBCC);

        // Backpressure on both response channels
        drive_aw(32'h0000_0014);
        drive_w(32'h0BAD_F00D, 4'hF);
        b_q.push_back(2'b00);
        run_handshakes("bp_wr");
        model_write(32'h0000_0014, 32'h0BAD_F00D, 4'hF);
        drive_ar(32'h0000_0008);
        r_q.push_back('{32'h99AA_BBCC, 2'b00});
        run_handshakes("bp_rd");
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            check("bp_valids",  {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
            check("bp_resps",   {S_AXI_BRESP, S_AXI_RRESP}, 4'b0000);
            check("bp_rdata",   S_AXI_RDATA, 32'h99AA_BBCC);
            check("bp_readys",  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
            @(posedge ACLK); #1;
        end
        collect_b("bp");
        collect_r("bp");
        check("bp_reg_out", reg_out, model_flat());

        // Write commit and read of the same register on one edge: read returns old value
        drive_aw(32'h0000_0014);
        drive_w(32'h1212_1212, 4'hF);
        drive_ar(32'h0000_0014);
        b_q.push_back(2'b00);
        r_q.push_back('{32'h0BAD_F00D, 2'b00});
        run_handshakes("collide");
        model_write(32'h0000_0014, 32'h1212_1212, 4'hF);
        collect_b("collide");
        collect_r("collide");
        do_read("collide_after", 32'h0000_0014, 32'h1212_1212, 2'b00);

        // Reset while both responses are pending
        drive_aw(32'h0000_0000);
        drive_w(32'h5A5A_5A5A, 4'hF);
        drive_ar(32'h0000_001C);
        run_handshakes("rst_mid");
        @(negedge ACLK);
        check("rst_mid_pending", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        #2;
        ARESETN = 1'b0;
        #1;
        check("rst_mid_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("rst_mid_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        check("rst_mid_reg_out", reg_out, '0);
        model_clear();
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("rst_mid_readys_back", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        do_write("after_rst_wr", 32'h0000_000C, 32'h1357_9BDF, 4'hF, 2'b00);
        do_read("after_rst_rd", 32'h0000_000C, 32'h1357_9BDF, 2'b00);
        do_read("after_rst_rd0", 32'h0000_0000, 32'h0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite responder (slave) fronting a memory-mapped register file of NUM_REGS words. It accepts single-beat reads and writes from an AXI4-Lite master. The write path (AW/W/B) and read path (AR/R) are independent state machines. The register contents are also exported as a flat bus so downstream logic can consume configuration values.

Parameters:
ADDRESS_WIDTH, 32, width of AWADDR/ARADDR
DATA_WIDTH, 32, data width; must be 32 or 64; strobe width is DATA_WIDTH/8
NUM_REGS, 8, number of registers; power of two, minimum 2

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESETN  input  1  asynchronous active-low reset
S_AXI_AWADDR  input  ADDRESS_WIDTH  write address
S_AXI_AWVALID  input  1  write address valid
S_AXI_AWREADY  output  1  write address ready
S_AXI_WDATA  input  DATA_WIDTH  write data
S_AXI_WSTRB  input  DATA_WIDTH/8  byte enables
S_AXI_WVALID  input  1  write data valid
S_AXI_WREADY  output  1  write data ready
S_AXI_BRESP  output  2  write response
S_AXI_BVALID  output  1  write response valid
S_AXI_BREADY  input  1  master ready for response
S_AXI_ARADDR  input  ADDRESS_WIDTH  read address
S_AXI_ARVALID  input  1  read address valid
S_AXI_ARREADY  output  1  read address ready
S_AXI_RDATA  output  DATA_WIDTH  read data
S_AXI_RRESP  output  2  read response
S_AXI_RVALID  output  1  read data valid
S_AXI_RREADY  input  1  master ready for read data
reg_out  output  NUM_REGS*DATA_WIDTH  register file contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All registers = 0.
  - BVALID, RVALID, BRESP, RRESP, RDATA = 0.
  - All READY outputs forced to 0 while ARESETN is low.
  - Both FSMs go to idle; capture flags are cleared.
  - Reset mid-transaction drops all pending transfers and responses.
- Address decode:
  - ADDR_LSB = log2(DATA_WIDTH/8). Index = addr[ADDR_LSB +: log2(NUM_REGS)].
  - addr bits below ADDR_LSB are ignored (unaligned addresses alias to the containing word).
  - addr >= NUM_REGS*(DATA_WIDTH/8) is out of range and returns SLVERR (2'b10).
  - In-range accesses return OKAY (2'b00).
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: AWREADY = !aw_captured; WREADY = !w_captured.
  - On an AW handshake, latch the address and set aw_captured. On a W handshake, latch data and strobe and set w_captured.
  - AW and W may arrive in either order or in the same cycle.
  - At the edge where both are held (including same-cycle arrival), commit the write and move to W_RESP.
  - Commit: for each byte b with WSTRB[b]=1, reg[idx] byte b = WDATA byte b. Other bytes are unchanged. WSTRB=0 writes nothing but still returns OKAY.
  - Out-of-range commit: no register changes; BRESP=SLVERR.
  - W_RESP: BVALID=1, AWREADY=WREADY=0. BRESP is held stable until BREADY.
  - On the BVALID&&BREADY edge: go to W_IDLE, clear capture flags, BVALID=0.
  - Latency: BVALID is high in the cycle after the final AW/W handshake. Minimum 2 cycles per write.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: ARREADY=1.
  - On the ARVALID handshake edge: RDATA = reg[idx] (0 if out of range), RRESP set, RVALID=1, go to R_DATA.
  - R_DATA: ARREADY=0. RDATA and RRESP are held until RREADY.
  - On the RVALID&&RREADY edge: RVALID=0, go to R_IDLE.
  - Latency: RVALID is high in the cycle after the AR handshake. Minimum 2 cycles per read.
- Read/write collision: a write commit and an AR handshake to the same register on the same edge return the OLD value. The new value is visible to later reads.
- reg_out reflects register state combinationally from the flops, updating the cycle after commit.
- VALID outputs never drop without a handshake. READY outputs do not depend combinationally on VALID inputs.

Test Plan:
- Reset, then AW=0x04 and W=0xDEADBEEF with WSTRB=4'hF in the same cycle → BVALID next cycle, BRESP=00; read 0x04 → RDATA=0xDEADBEEF, RRESP=00, reg_out[63:32]=0xDEADBEEF.
- W (0x11223344) presented 3 cycles before AW=0x08 → WREADY drops after W is taken, AWREADY stays high until AW arrives; BVALID the cycle after AW; reg2=0x11223344. Repeat with AW before W, same result.
- reg1=0xDEADBEEF, write 0x000000AA with WSTRB=4'b0001 to 0x04 → reg1=0xDEADBEAA; WSTRB=0 → unchanged, BRESP=00.
- Write to 0x20 and read 0x24 with NUM_REGS=8 → BRESP=10, RRESP=10, RDATA=0, no register changes.
- Hold BREADY/RREADY low for 5 cycles → BVALID/RVALID, BRESP/RRESP and RDATA stay stable, AWREADY/WREADY/ARREADY stay 0; complete when READY rises.
- Drop ARESETN while BVALID=1 and RVALID=1 → both go to 0 immediately, registers=0; after release, READYs=1 and a new write completes normally.
